// File: rtl/ext_mem_responder.sv
// ext_mem_responder: target-side responder for the external memory region.
// Accepts a CPU access while cs is high and inserts WAIT_CYCLES wait states.
// Reads or writes a small word-addressed storage array, then completes with a
// registered one-cycle ready pulse. err flags accesses outside the mapped window.
module ext_mem_responder #(
  parameter logic [31:0] EXT_BASE    = 32'h0000_1B30,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        Clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adress,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_N = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state_q, state_d;

  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             we_q, we_d;
  logic             hit_q, hit_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      dout_q, dout_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             mem_we;

  logic [31:0] mem_q [DEPTH];

  logic [31:0] offset;
  logic        hit;
  logic        accept;

  // The unsigned wrap of the subtraction makes below-base addresses fail the
  // DEPTH bound, so the lower-bound test mainly guards very large DEPTH values.
  assign offset = adress - EXT_BASE;
  assign hit    = (adress >= EXT_BASE) && (offset < 32'(DEPTH));
  assign accept = (state_q == S_IDLE) && req && cs;

  // State register
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (WAIT_N != 4'd0) ? S_WAIT : S_RESP;
      S_WAIT: if (cnt_q == WAIT_N) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values: latch on accept, count waits, complete in RESP
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    hit_d   = hit_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          idx_d   = offset[IDX_W-1:0];
          we_d    = we;
          hit_d   = hit;
          wdata_d = DataIn;
          busy_d  = 1'b1;
          cnt_d   = 4'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_N) cnt_d = '0;
        else                 cnt_d = cnt_q + 4'd1;
      end
      S_RESP: begin
        cnt_d   = '0;
        ready_d = 1'b1;
        err_d   = ~hit_q;
        busy_d  = 1'b0;
        mem_we  = we_q & hit_q;
        if (!we_q) dout_d = hit_q ? mem_q[idx_q] : ERR_DATA;
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      wdata_q <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      hit_q   <= hit_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Storage write, committed in RESP; contents survive reset
  always_ff @(posedge Clk) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

  assign DataOut = dout_q;
  assign ready   = ready_q;
  assign err     = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Self-checking bench for ext_mem_responder: one instance with 3 wait states,
// one with zero wait states for the back-to-back timing case.
module tb_ext_mem_responder;

  logic        Clk;
  logic        rst;
  logic        req;
  logic        we;
  logic        cs3;
  logic        cs0;
  logic [31:0] adr;
  logic [31:0] din;
  logic [31:0] dout3, dout0;
  logic        ready3, err3, busy3;
  logic        ready0, err0, busy0;

  int checks;
  int failures;

  ext_mem_responder #(
    .EXT_BASE(32'h0000_1B30), .DEPTH(256), .WAIT_CYCLES(3), .ERR_DATA(32'hDEAD_BEEF)
  ) dut3 (
    .Clk(Clk), .rst(rst), .cs(cs3), .req(req), .we(we), .adress(adr), .DataIn(din),
    .DataOut(dout3), .ready(ready3), .err(err3), .busy(busy3)
  );

  ext_mem_responder #(
    .EXT_BASE(32'h0000_1B30), .DEPTH(256), .WAIT_CYCLES(0), .ERR_DATA(32'hDEAD_BEEF)
  ) dut0 (
    .Clk(Clk), .rst(rst), .cs(cs0), .req(req), .we(we), .adress(adr), .DataIn(din),
    .DataOut(dout0), .ready(ready0), .err(err0), .busy(busy0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One complete access on the selected instance (sel=1 -> zero-wait instance).
  task automatic access(input bit sel, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] dout,
                        output logic e, output int lat, output bit busy_ok);
    @(negedge Clk);
    we = w; adr = a; din = d; req = 1'b1;
    if (sel) cs0 = 1'b1; else cs3 = 1'b1;
    @(posedge Clk); #1;
    busy_ok = ((sel ? busy0 : busy3) === 1'b1);
    lat = 0;
    for (int n = 1; n <= 32; n++) begin
      @(posedge Clk); #1;
      if ((sel ? ready0 : ready3) === 1'b1) begin
        lat = n;
        break;
      end
      if ((sel ? busy0 : busy3) !== 1'b1) busy_ok = 1'b0;
    end
    dout = sel ? dout0 : dout3;
    e    = sel ? err0 : err3;
    @(negedge Clk);
    req = 1'b0; cs3 = 1'b0; cs0 = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        chk_d;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t vecs [16];

  logic [31:0] r_dout;
  logic        r_err;
  int          r_lat;
  bit          r_busy;

  initial begin
    checks = 0;
    failures = 0;

    //            we    adress        DataIn        chk   DataOut       err
    vecs[0]  = '{1'b0, 32'h0000_1B30, 32'h0,        1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 32'h0000_1B35, 32'h1234_5678, 1'b0, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 32'h0000_1B35, 32'h0,        1'b1, 32'h1234_5678, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_1B36, 32'h0,        1'b0, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h0000_1B35, 32'h0,        1'b1, 32'h1234_5678, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_1B30, 32'hCAFE_F00D, 1'b1, 32'h1234_5678, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_1B2F, 32'h0,        1'b1, 32'hDEAD_BEEF, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_1C30, 32'h0,        1'b1, 32'hDEAD_BEEF, 1'b1};
    vecs[8]  = '{1'b1, 32'h0000_1C2F, 32'h0BAD_F00D, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_1C30, 32'h1111_1111, 1'b1, 32'hDEAD_BEEF, 1'b1};
    vecs[10] = '{1'b1, 32'h0000_1B2F, 32'h2222_2222, 1'b1, 32'hDEAD_BEEF, 1'b1};
    vecs[11] = '{1'b0, 32'h0000_1B30, 32'h0,        1'b1, 32'hCAFE_F00D, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_1C2F, 32'h0,        1'b1, 32'h0BAD_F00D, 1'b0};
    vecs[13] = '{1'b0, 32'hFFFF_FFFF, 32'h0,        1'b1, 32'hDEAD_BEEF, 1'b1};
    vecs[14] = '{1'b1, 32'h0000_1B40, 32'hA5A5_0001, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[15] = '{1'b0, 32'h0000_1B40, 32'h0,        1'b1, 32'hA5A5_0001, 1'b0};

    rst = 1'b0; req = 1'b0; we = 1'b0; cs3 = 1'b0; cs0 = 1'b0; adr = '0; din = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_dout", dout3, 32'h0);
    chk("reset_ready_err_busy", {29'h0, ready3, err3, busy3}, 32'h0);
    chk("reset_dout_w0", dout0, 32'h0);
    @(negedge Clk) rst = 1'b1;

    // Table of single accesses on the 3-wait-state instance
    for (int i = 0; i < 16; i++) begin
      access(1'b0, vecs[i].w, vecs[i].a, vecs[i].d, r_dout, r_err, r_lat, r_busy);
      chk($sformatf("vec%0d_latency", i), 32'(r_lat), 32'd4);
      chk($sformatf("vec%0d_err", i), {31'h0, r_err}, {31'h0, vecs[i].exp_e});
      chk($sformatf("vec%0d_busy", i), {31'h0, r_busy}, 32'h1);
      if (vecs[i].chk_d) chk($sformatf("vec%0d_dout", i), r_dout, vecs[i].exp_d);
      @(posedge Clk); #1;
      chk($sformatf("vec%0d_ready_pulse", i), {31'h0, ready3}, 32'h0);
      chk($sformatf("vec%0d_busy_after", i), {31'h0, busy3}, 32'h0);
    end

    // req without cs is ignored for 10 cycles
    @(negedge Clk);
    req = 1'b1; cs3 = 1'b0; we = 1'b0; adr = 32'h0000_1B35;
    for (int c = 0; c < 10; c++) begin
      @(posedge Clk); #1;
      chk($sformatf("nocs_cyc%0d", c), {29'h0, ready3, err3, busy3}, 32'h0);
    end
    chk("nocs_dout_hold", dout3, 32'hA5A5_0001);
    @(negedge Clk) req = 1'b0;

    // Reset two cycles into a store: outputs clear at once, store discarded
    @(negedge Clk);
    req = 1'b1; cs3 = 1'b1; we = 1'b1; adr = 32'h0000_1B40; din = 32'h5555_AAAA;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    rst = 1'b0;
    #1;
    chk("midrst_dout", dout3, 32'h0);
    chk("midrst_ready_err_busy", {29'h0, ready3, err3, busy3}, 32'h0);
    req = 1'b0; cs3 = 1'b0;
    @(negedge Clk) rst = 1'b1;
    access(1'b0, 1'b0, 32'h0000_1B40, 32'h0, r_dout, r_err, r_lat, r_busy);
    chk("midrst_load_dout", r_dout, 32'hA5A5_0001);
    chk("midrst_load_latency", 32'(r_lat), 32'd4);

    // Zero-wait instance: single-access latency, then back-to-back loads
    access(1'b1, 1'b1, 32'h0000_1B50, 32'h0000_0050, r_dout, r_err, r_lat, r_busy);
    chk("w0_store_latency", 32'(r_lat), 32'd1);
    chk("w0_store_err", {31'h0, r_err}, 32'h0);
    access(1'b1, 1'b1, 32'h0000_1B51, 32'h0000_0051, r_dout, r_err, r_lat, r_busy);
    chk("w0_store2_latency", 32'(r_lat), 32'd1);

    @(negedge Clk);
    req = 1'b1; cs0 = 1'b1; we = 1'b0; adr = 32'h0000_1B50;
    @(posedge Clk); #1;
    chk("b2b_first_accept", {30'h0, busy0, ready0}, 32'h2);
    @(posedge Clk); #1;
    chk("b2b_first_ready", {31'h0, ready0}, 32'h1);
    chk("b2b_first_dout", dout0, 32'h0000_0050);
    @(negedge Clk) adr = 32'h0000_1B51;
    @(posedge Clk); #1;
    chk("b2b_second_accept", {30'h0, busy0, ready0}, 32'h2);
    @(posedge Clk); #1;
    chk("b2b_second_ready", {31'h0, ready0}, 32'h1);
    chk("b2b_second_dout", dout0, 32'h0000_0051);
    @(negedge Clk);
    req = 1'b0; cs0 = 1'b0;
    @(posedge Clk); #1;
    chk("b2b_idle_after", {30'h0, busy0, ready0}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ext_mem_responder.md
Name: ext_mem_responder

Overview:
- Target-side responder for the external memory region.
- Services CPU load/store accesses when the address decoder drives cs=1, meaning the access is outside the internal-memory window.
- Models a slower off-chip memory with a small word-addressed storage array, a programmable number of wait states and a ready/err completion handshake.
- Sits beside the internal data memory. Its DataOut is selected by the CPU-side read mux whenever cs=1.

Parameters:
- EXT_BASE, 32'h00001B30, first word address mapped into the external storage.
- DEPTH, 256, number of 32-bit words stored (power of two, ≤ 4096).
- WAIT_CYCLES, 3, wait states inserted between acceptance and completion (0..15).
- ERR_DATA, 32'hDEADBEEF, read data returned for unmapped external addresses.

Ports:
- Clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- cs  input  1  chip select from the address decoder: 1 = external access, 0 = internal (ignore).
- req  input  1  access request. CPU holds req, adress, we and DataIn stable until ready.
- we  input  1  1 = store, 0 = load.
- adress  input  32  word address of the access.
- DataIn  input  32  store data.
- DataOut  output  32  load data, valid in the ready cycle and held until the next completion.
- ready  output  1  one-cycle completion pulse.
- err  output  1  asserted with ready when the access was unmapped.
- busy  output  1  high from acceptance until completion (inclusive).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; DataOut=0, ready=0, err=0, busy=0; wait counter=0. Storage contents are not reset.
- Mapped condition: adress ≥ EXT_BASE and (adress − EXT_BASE) < DEPTH. The 32-bit subtraction is unsigned. Index = low log2(DEPTH) bits of the difference.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req=1 and cs=1, latch adress, we, DataIn and mapped; set busy=1.
  - Go to WAIT if WAIT_CYCLES>0, else to RESP.
  - req=1 with cs=0 is ignored: no state change, no ready.
- WAIT:
  - Counter counts 1..WAIT_CYCLES; go to RESP after the WAIT_CYCLES-th cycle.
  - Inputs are not resampled; the latched values are used.
- RESP (one cycle), then back to IDLE:
  - Mapped store: write latched DataIn to storage[index]; DataOut unchanged; ready=1, err=0.
  - Mapped load: DataOut=storage[index]; ready=1, err=0.
  - Unmapped load: DataOut=ERR_DATA; ready=1, err=1.
  - Unmapped store: storage unchanged; ready=1, err=1.
  - busy is deasserted on the following cycle.
- Latency: ready is asserted exactly WAIT_CYCLES+1 cycles after the acceptance edge. Back-to-back: a new request can be accepted in the first IDLE cycle after RESP.
- req or cs dropping mid-transaction does not abort the access; it completes normally.
- ready and err are registered outputs with no combinational path from inputs.
- Reset mid-transaction: the access is discarded. A pending store does not write. Outputs return to reset values immediately.
- A store followed by a load to the same address returns the new data (write committed in RESP).

Test Plan:
- Reset, then load adress=0x1B30 with cs=1, WAIT_CYCLES=3 -> ready pulses 4 cycles after acceptance; busy high during those 4 cycles; err=0.
- Store 0x12345678 to 0x1B35, then load 0x1B35 -> DataOut=0x12345678, err=0. Load 0x1B36 (never written) leaves 0x1B35 unaffected.
- Load 0x1B2F (below base) and 0x1C30 (base+DEPTH) with cs=1 -> DataOut=0xDEADBEEF, err=1, ready=1. Unmapped store followed by a load of 0x1B30 shows unchanged content.
- req=1, cs=0 for 10 cycles -> ready, busy and err stay 0; DataOut holds its previous value.
- Assert rst=0 two cycles into a store to 0x1B40 -> outputs clear immediately. After release, a load of 0x1B40 returns the prior (unwritten) content.
- WAIT_CYCLES=0, two back-to-back loads -> each ready one cycle after its acceptance. The second request is accepted the cycle after the first ready.
